// File: rtl/wb_ddr_arbiter.sv
// wb_ddr_arbiter: round-robin Wishbone B3 arbiter that shares the single DDR
// slave port (in front of the wb2axi bridge) among NUM_MASTERS requesters.
// A master owns the bus for a whole cycle (cyc asserted), so classic cycles
// and incrementing bursts reach the bridge unbroken.
// Optional stall watchdog and LOCKOUT state: define WB_ARB_TIMEOUT_EN.
module wb_ddr_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_WIDTH  = 28,
    parameter int DATA_WIDTH  = 32,
    parameter int TIMEOUT     = 1024
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [NUM_MASTERS-1:0]              m_cyc_i,
    input  logic [NUM_MASTERS-1:0]              m_stb_i,
    input  logic [NUM_MASTERS-1:0]              m_we_i,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]   m_adr_i,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0]   m_dat_i,
    input  logic [NUM_MASTERS*DATA_WIDTH/8-1:0] m_sel_i,
    input  logic [NUM_MASTERS*3-1:0]            m_cti_i,
    input  logic [NUM_MASTERS*2-1:0]            m_bte_i,
    output logic [NUM_MASTERS-1:0]              m_ack_o,
    output logic [NUM_MASTERS-1:0]              m_err_o,
    output logic [NUM_MASTERS-1:0]              m_rty_o,
    output logic [DATA_WIDTH-1:0]               m_dat_o,
    output logic                                s_cyc_o,
    output logic                                s_stb_o,
    output logic                                s_we_o,
    output logic [ADDR_WIDTH-1:0]               s_adr_o,
    output logic [DATA_WIDTH-1:0]               s_dat_o,
    output logic [DATA_WIDTH/8-1:0]             s_sel_o,
    output logic [2:0]                          s_cti_o,
    output logic [1:0]                          s_bte_o,
    input  logic                                s_ack_i,
    input  logic                                s_err_i,
    input  logic                                s_rty_i,
    input  logic [DATA_WIDTH-1:0]               s_dat_i,
    output logic [NUM_MASTERS-1:0]              grant_o,
    output logic                                timeout_o
);

    localparam int SEL_WIDTH = DATA_WIDTH / 8;
    localparam int IDX_W     = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    if (NUM_MASTERS < 1 || NUM_MASTERS > 8 || TIMEOUT < 2) begin : g_bad_params
        $error("wb_ddr_arbiter: NUM_MASTERS must be 1..8 and TIMEOUT at least 2");
    end

`ifdef WB_ARB_TIMEOUT_EN
    typedef enum logic [1:0] {IDLE, BUSY, LOCKOUT} state_t;
`else
    typedef enum logic [0:0] {IDLE, BUSY} state_t;
`endif

    state_t state;
    state_t state_next;

    logic [IDX_W-1:0]       owner;
    logic [IDX_W-1:0]       last;
    logic [IDX_W-1:0]       pick_idx;
    logic                   pick_valid;
    logic                   rearb;
    logic                   owner_cyc;
    logic                   owner_stb;
    logic [NUM_MASTERS-1:0] grant;

    logic [ADDR_WIDTH-1:0] adr_arr [NUM_MASTERS];
    logic [DATA_WIDTH-1:0] dat_arr [NUM_MASTERS];
    logic [SEL_WIDTH-1:0]  sel_arr [NUM_MASTERS];
    logic [2:0]            cti_arr [NUM_MASTERS];
    logic [1:0]            bte_arr [NUM_MASTERS];

    // Split the packed per-master buses into arrays indexed by master number.
    for (genvar k = 0; k < NUM_MASTERS; k++) begin : g_unpack
        assign adr_arr[k] = m_adr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
        assign dat_arr[k] = m_dat_i[k*DATA_WIDTH +: DATA_WIDTH];
        assign sel_arr[k] = m_sel_i[k*SEL_WIDTH +: SEL_WIDTH];
        assign cti_arr[k] = m_cti_i[k*3 +: 3];
        assign bte_arr[k] = m_bte_i[k*2 +: 2];
    end

    assign owner_cyc = m_cyc_i[owner];
    assign owner_stb = m_cyc_i[owner] & m_stb_i[owner];
    assign grant_o   = grant;

    // Round-robin pick: first requester above last wins, otherwise wrap to the lowest.
    always_comb begin
        logic             hi_found;
        logic             lo_found;
        logic [IDX_W-1:0] hi_idx;
        logic [IDX_W-1:0] lo_idx;
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
            if (m_cyc_i[k]) begin
                if (k > int'(last)) begin
                    hi_found = 1'b1;
                    hi_idx   = IDX_W'(k);
                end else begin
                    lo_found = 1'b1;
                    lo_idx   = IDX_W'(k);
                end
            end
        end
        pick_valid = hi_found | lo_found;
        pick_idx   = hi_found ? hi_idx : lo_idx;
    end

`ifdef WB_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT);

    logic [CNT_W-1:0] cnt;
    logic             term;
    logic             tmo_hit;
    logic             tmo_flag;

    assign term    = s_ack_i | s_err_i | s_rty_i;
    assign tmo_hit = (state == BUSY) && owner_stb && !term && (cnt == CNT_W'(TIMEOUT - 1));

    // Watchdog counts stalled strobe cycles; tmo_flag marks the first LOCKOUT cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            tmo_flag <= 1'b0;
        end else begin
            tmo_flag <= tmo_hit;
            if (state != BUSY || rearb || term || tmo_hit) begin
                cnt <= '0;
            end else if (owner_stb) begin
                cnt <= cnt + 1'b1;
            end
        end
    end
`endif

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: re-arbitrate when idle or when the owner releases cyc.
    always_comb begin
        state_next = state;
        rearb      = 1'b0;
        case (state)
            IDLE: rearb = 1'b1;
            BUSY: begin
                if (!owner_cyc) begin
                    rearb = 1'b1;
`ifdef WB_ARB_TIMEOUT_EN
                end else if (tmo_hit) begin
                    state_next = LOCKOUT;
`endif
                end
            end
`ifdef WB_ARB_TIMEOUT_EN
            LOCKOUT: rearb = !owner_cyc;
`endif
            default: rearb = 1'b1;
        endcase
        if (rearb) begin
            state_next = pick_valid ? BUSY : IDLE;
        end
    end

    // Ownership registers: owner index, one-hot grant and last owner for round-robin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner <= '0;
            last  <= IDX_W'(NUM_MASTERS - 1);
            grant <= '0;
        end else if (rearb) begin
            if (pick_valid) begin
                owner <= pick_idx;
                last  <= pick_idx;
                grant <= NUM_MASTERS'(1) << pick_idx;
            end else begin
                grant <= '0;
            end
        end
    end

    // Output mux: only the owner reaches the slave and only the owner sees terminations.
    always_comb begin
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_we_o  = 1'b0;
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        s_cti_o = '0;
        s_bte_o = '0;
        m_ack_o = '0;
        m_err_o = '0;
        m_rty_o = '0;
        m_dat_o = '0;
        if (state == BUSY) begin
            s_cyc_o        = owner_cyc;
            s_stb_o        = owner_stb;
            s_we_o         = m_we_i[owner];
            s_adr_o        = adr_arr[owner];
            s_dat_o        = dat_arr[owner];
            s_sel_o        = sel_arr[owner];
            s_cti_o        = cti_arr[owner];
            s_bte_o        = bte_arr[owner];
            m_ack_o[owner] = s_ack_i;
            m_err_o[owner] = s_err_i;
            m_rty_o[owner] = s_rty_i;
            m_dat_o        = s_dat_i;
        end
`ifdef WB_ARB_TIMEOUT_EN
        timeout_o = tmo_flag;
        if (state == LOCKOUT) begin
            m_err_o[owner] = tmo_flag;
        end
`else
        timeout_o = 1'b0;
`endif
    end

endmodule
